// File: rtl/ex_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_if
// Purpose : bundles the ID/EX-side request signals and the hazard/forwarding
//           responses exchanged between the pipeline and ex_hazard_ctrl.
// Signals :
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_load
//                 - description of the instruction currently in ID
//   ex_br_taken   - EX resolved a taken branch/call/ret this cycle
//   stall         - hold PC and IF/ID (combinational)
//   flush         - squash IF/ID and ID/EX (registered)
//   bubble        - ID/EX loads a NOP on the next edge (combinational)
//   fwd_a, fwd_b  - EX operand selects: 00 regfile, 01 MEM result, 10 WB data
// Modports: master = pipeline side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface ex_hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wr;
    logic [REG_W-1:0] id_rd;
    logic             id_load;
    logic             ex_br_taken;
    logic             stall;
    logic             flush;
    logic             bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr, id_rd, id_load, ex_br_taken,
        input  stall, flush, bubble, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr, id_rd, id_load, ex_br_taken,
        output stall, flush, bubble, fwd_a, fwd_b
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl
// Purpose : hazard / forwarding controller for the EX stage of a 5-stage pipe.
//           Shadows the destination info of the instructions in EX, MEM and WB,
//           produces registered operand-forward selects for the instruction
//           entering EX, detects load-use hazards (one stall + bubble), and
//           sequences the post-branch flush window. Owns no datapath.
// Ports   :
//   clk        - clock, all state on the rising edge
//   rst        - synchronous reset, active-low
//   ext_stall  - global freeze; holds all state
//   hz_if      - ex_hazard_ctrl_if.slave (ID request / hazard responses)
//   stall_cnt  - load-use stall cycles (perf)
//   flush_cnt  - taken-branch flush events (perf)
// Configuration macro: HAZARD_PERF_EN enables the saturating perf counters;
//   without it both counter outputs are constant zero and no flops exist.
// ---------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    ex_hazard_ctrl_if.slave  hz_if,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam slot_t      SLOT_EMPTY = '{v: 1'b0, wr: 1'b0, rd: {REG_W{1'b0}}, ld: 1'b0};
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    // A slot supplies register r only if it is a real GPR write; r0 never matches.
    function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
        return s.v & s.wr & (s.rd == r) & (r != {REG_W{1'b0}});
    endfunction

    // EX-stage producers forward from MEM next cycle unless they are loads;
    // the younger producer wins over the WB-side copy.
    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input logic [REG_W-1:0] r);
        logic [1:0] sel;
        if (slot_match(ex_s, r) & ~ex_s.ld) begin
            sel = 2'b01;
        end else if (slot_match(mem_s, r)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    slot_t      r_ex_q, r_mem_q, r_wb_q;
    logic [1:0] r_fwd_a, r_fwd_b;
    state_t     r_state;
    logic [2:0] r_cnt;

    state_t     w_state_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_flush_start;
    logic       w_flush;
    logic       w_hz;
    logic       w_stall;
    logic       w_bubble;
    logic       w_kill;
    slot_t      w_ex_d;
    logic [1:0] w_fwd_a_d, w_fwd_b_d;

    assign w_flush = (r_state == ST_FLUSH);

    // Load-use detection, stall/bubble generation and next ID/EX contents.
    always_comb begin
        w_hz = hz_if.id_valid & r_ex_q.ld &
               ((hz_if.id_use_rs & slot_match(r_ex_q, hz_if.id_rs)) |
                (hz_if.id_use_rt & slot_match(r_ex_q, hz_if.id_rt)));
        // A taken branch (now or in progress) squashes ID anyway, so no stall.
        w_stall  = w_hz & ~hz_if.ex_br_taken & ~w_flush;
        w_bubble = w_stall | w_flush;
        w_kill   = w_bubble | hz_if.ex_br_taken | ~hz_if.id_valid;
        if (w_kill) begin
            w_ex_d    = SLOT_EMPTY;
            w_fwd_a_d = 2'b00;
            w_fwd_b_d = 2'b00;
        end else begin
            w_ex_d    = '{v: 1'b1, wr: hz_if.id_wr, rd: hz_if.id_rd, ld: hz_if.id_load};
            w_fwd_a_d = fwd_sel(r_ex_q, r_mem_q, hz_if.id_rs);
            w_fwd_b_d = fwd_sel(r_ex_q, r_mem_q, hz_if.id_rt);
        end
    end

    // Flush FSM next-state: a branch in IDLE opens a FLUSH_CYCLES-long window.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flush_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (hz_if.ex_br_taken) begin
                    w_state_nxt   = ST_FLUSH;
                    w_cnt_nxt     = FLUSH_LOAD;
                    w_flush_start = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Further taken branches here come from squashed slots: ignored.
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else if (!ext_stall) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow pipeline slots and registered forward selects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_q  <= SLOT_EMPTY;
            r_mem_q <= SLOT_EMPTY;
            r_wb_q  <= SLOT_EMPTY;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else if (!ext_stall) begin
            r_wb_q  <= r_mem_q;
            r_mem_q <= r_ex_q;
            r_ex_q  <= w_ex_d;
            r_fwd_a <= w_fwd_a_d;
            r_fwd_b <= w_fwd_b_d;
        end
    end

    assign hz_if.stall  = w_stall;
    assign hz_if.bubble = w_bubble;
    assign hz_if.flush  = w_flush;
    assign hz_if.fwd_a  = r_fwd_a;
    assign hz_if.fwd_b  = r_fwd_b;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating perf counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else if (!ext_stall) begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_start && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed pipeline scenarios with literal
// expectations, then randomized traffic, all checked every cycle against an
// instruction-history model of the pipeline.
module tb_ex_hazard_ctrl;
    localparam int REG_W        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ext_stall = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.REG_W(REG_W)) hif();

    ex_hazard_ctrl #(
        .REG_W(REG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .hz_if(hif),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit wr;
        int rd;
        bit ld;
    } ins_t;

    ins_t hist[$];        // [0] = instruction in EX, [1] = MEM, [2] = WB
    int   flush_left;     // flush cycles still to come
    int   exp_fa, exp_fb;
    int   m_stall_cnt, m_flush_cnt;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 1'b0; e.wr = 1'b0; e.rd = 0; e.ld = 1'b0;
        return e;
    endfunction

    function automatic bit m_match(input ins_t e, input int r);
        return e.v && e.wr && (e.rd == r) && (r != 0);
    endfunction

    function automatic bit m_stall();
        bit hz;
        hz = hif.id_valid && hist[0].ld &&
             ((hif.id_use_rs && m_match(hist[0], int'(hif.id_rs))) ||
              (hif.id_use_rt && m_match(hist[0], int'(hif.id_rt))));
        return hz && !hif.ex_br_taken && (flush_left == 0);
    endfunction

    function automatic bit m_bubble();
        return m_stall() || (flush_left > 0);
    endfunction

    function automatic int m_pick(input int r);
        if (m_match(hist[0], r) && !hist[0].ld) return 1;
        if (m_match(hist[1], r)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(empty_ins());
        flush_left = 0; exp_fa = 0; exp_fb = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // Called at each rising edge with the inputs the DUT samples there.
    task automatic model_step();
        bit   s, kill;
        ins_t nx;
        int   fa, fb;
        if (!rst) begin
            model_reset();
        end else if (!ext_stall) begin
            s    = m_stall();
            kill = m_bubble() || hif.ex_br_taken || !hif.id_valid;
            if (s && m_stall_cnt < (1 << CNT_W) - 1) m_stall_cnt++;
            if (kill) begin
                nx = empty_ins(); fa = 0; fb = 0;
            end else begin
                nx.v = 1'b1; nx.wr = hif.id_wr; nx.rd = int'(hif.id_rd); nx.ld = hif.id_load;
                fa = m_pick(int'(hif.id_rs));
                fb = m_pick(int'(hif.id_rt));
            end
            if (flush_left > 0) begin
                flush_left--;
            end else if (hif.ex_br_taken) begin
                flush_left = FLUSH_CYCLES;
                if (m_flush_cnt < (1 << CNT_W) - 1) m_flush_cnt++;
            end
            hist.push_front(nx);
            void'(hist.pop_back());
            exp_fa = fa; exp_fb = fb;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",  32'(hif.stall),  32'(m_stall()));
            check("bubble", 32'(hif.bubble), 32'(m_bubble()));
            check("flush",  32'(hif.flush),  32'(flush_left > 0));
            check("fwd_a",  32'(hif.fwd_a),  32'(exp_fa));
            check("fwd_b",  32'(hif.fwd_b),  32'(exp_fb));
`ifdef HAZARD_PERF_EN
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
            check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`else
            check("stall_cnt", 32'(stall_cnt), 32'd0);
            check("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic id_set(input bit v, input int rs, input int rt, input bit urs,
                          input bit urt, input bit wr, input int rd, input bit ld);
        hif.id_valid  = v;
        hif.id_rs     = REG_W'(rs);
        hif.id_rt     = REG_W'(rt);
        hif.id_use_rs = urs;
        hif.id_use_rt = urt;
        hif.id_wr     = wr;
        hif.id_rd     = REG_W'(rd);
        hif.id_load   = ld;
    endtask

    task automatic idle();
        id_set(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        idle();
        hif.ex_br_taken = 1'b0;
        model_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        chk_en = 1'b1;
        at_neg();
        check("rst_stall", 32'(hif.stall), 32'd0);
        check("rst_flush", 32'(hif.flush), 32'd0);
        check("rst_fwd_a", 32'(hif.fwd_a), 32'd0);

        // 1: ADD r3 then SUB r3,r4 -> EX->MEM forward on A
        id_set(1, 1, 2, 1, 1, 1, 3, 0); step();
        id_set(1, 3, 4, 1, 1, 1, 5, 0);
        at_neg(); check("t1_stall", 32'(hif.stall), 32'd0);
        step(); idle();
        at_neg(); check("t1_fwd_a", 32'(hif.fwd_a), 32'd1);
        check("t1_fwd_b", 32'(hif.fwd_b), 32'd0);

        // 2: ADD r5, NOP, XOR r1,r5 -> WB forward on B
        id_set(1, 1, 2, 1, 1, 1, 5, 0); step();
        idle(); step();
        id_set(1, 1, 5, 1, 1, 1, 6, 0); step(); idle();
        at_neg(); check("t2_fwd_b", 32'(hif.fwd_b), 32'd2);
        check("t2_fwd_a", 32'(hif.fwd_a), 32'd0);
        // ADD r5, ADD r5, use r5 -> MEM wins
        id_set(1, 1, 2, 1, 1, 1, 5, 0); step();
        id_set(1, 1, 2, 1, 1, 1, 5, 0); step();
        id_set(1, 5, 1, 1, 1, 1, 7, 0); step(); idle();
        at_neg(); check("t2_mem_wins", 32'(hif.fwd_a), 32'd1);

        // 3: LW r2 then ADD r2 -> one stall cycle, then WB forward
        id_set(1, 1, 1, 1, 0, 1, 2, 1); step();
        id_set(1, 2, 3, 1, 1, 1, 7, 0);
        at_neg(); check("t3_stall", 32'(hif.stall), 32'd1);
        check("t3_bubble", 32'(hif.bubble), 32'd1);
        step();
        at_neg(); check("t3_stall_end", 32'(hif.stall), 32'd0);
        step(); idle();
        at_neg(); check("t3_fwd_a", 32'(hif.fwd_a), 32'd2);
`ifdef HAZARD_PERF_EN
        check("t3_stall_cnt", 32'(stall_cnt), 32'd1);
`endif

        // 5: load to r0 then read r0 -> no stall, no forward
        id_set(1, 1, 1, 1, 0, 1, 0, 1); step();
        id_set(1, 0, 0, 1, 1, 1, 8, 0);
        at_neg(); check("t5_stall", 32'(hif.stall), 32'd0);
        step(); idle();
        at_neg(); check("t5_fwd_a", 32'(hif.fwd_a), 32'd0);
        check("t5_fwd_b", 32'(hif.fwd_b), 32'd0);

        // 4: taken branch -> 2 flush cycles; second taken ignored
        id_set(1, 1, 2, 1, 1, 1, 9, 0);
        hif.ex_br_taken = 1'b1; step();
        at_neg(); check("t4_flush1", 32'(hif.flush), 32'd1);
        check("t4_bubble", 32'(hif.bubble), 32'd1);
        step(); hif.ex_br_taken = 1'b0;
        at_neg(); check("t4_flush2", 32'(hif.flush), 32'd1);
        step();
        at_neg(); check("t4_flush_end", 32'(hif.flush), 32'd0);
`ifdef HAZARD_PERF_EN
        check("t4_flush_cnt", 32'(flush_cnt), 32'd1);
`endif
        idle(); step();

        // 6: ext_stall during load-use stall, then reset mid-flush
        id_set(1, 1, 1, 1, 0, 1, 2, 1); step();
        id_set(1, 2, 3, 1, 1, 1, 7, 0);
        ext_stall = 1'b1;
        at_neg(); check("t6_stall0", 32'(hif.stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg(); check("t6_frozen", 32'(hif.stall), 32'd1);
        end
        ext_stall = 1'b0;
        step();
        at_neg(); check("t6_released", 32'(hif.stall), 32'd0);
        step(); idle();
        at_neg(); check("t6_fwd_a", 32'(hif.fwd_a), 32'd2);
        hif.ex_br_taken = 1'b1; step();
        hif.ex_br_taken = 1'b0;
        at_neg(); check("t6_flush", 32'(hif.flush), 32'd1);
        rst = 1'b0; step(); rst = 1'b1;
        at_neg(); check("t6_rst_flush", 32'(hif.flush), 32'd0);
        check("t6_rst_fwd_a", 32'(hif.fwd_a), 32'd0);
        check("t6_rst_stall", 32'(hif.stall), 32'd0);

        // Randomized traffic over a small register window to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            id_set(($urandom_range(3) != 0),
                   int'($urandom_range(3)), int'($urandom_range(3)),
                   1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(4) != 0), int'($urandom_range(3)),
                   ($urandom_range(9) < 3));
            hif.ex_br_taken = ($urandom_range(99) < 8);
            ext_stall       = ($urandom_range(99) < 10);
            rst             = ($urandom_range(199) != 0);
            step();
        end
        rst = 1'b1; ext_stall = 1'b0; hif.ex_br_taken = 1'b0; idle();
        step();
        at_neg();
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
